// File: rtl/data_mem_responder_if.sv
// MEM-stage data-memory request/response bundle: the pipeline is the master, the responder is the slave.
interface data_mem_responder_if;
   logic [1:0]  MEM;
   logic [31:0] Addr;
   logic [31:0] Wdata;
   logic [31:0] Rdata;
   logic        BUSY;

   modport master (output MEM, Addr, Wdata, input  Rdata, BUSY);
   modport slave  (input  MEM, Addr, Wdata, output Rdata, BUSY);
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: direct-mapped write-through/no-allocate cache over a fixed-latency backing array.
// Optional DMR_STATS_EN adds hit/miss/store counters as outputs.
module data_mem_responder #(
   parameter int unsigned LINES    = 16,
   parameter int unsigned MEM_AW   = 10,
   parameter int unsigned MISS_LAT = 4,
   parameter int unsigned WR_LAT   = 2
) (
   input  logic                clk,
   input  logic                rst,
   data_mem_responder_if.slave bus
`ifdef DMR_STATS_EN
   ,
   output logic [31:0]         hit_cnt,
   output logic [31:0]         miss_cnt,
   output logic [31:0]         store_cnt
`endif
);
   localparam int unsigned IDX_W   = $clog2(LINES);
   localparam int unsigned TAG_W   = MEM_AW - IDX_W;
   localparam int unsigned MAX_LAT = (MISS_LAT > WR_LAT) ? MISS_LAT : WR_LAT;
   localparam int unsigned CNT_W   = $clog2(MAX_LAT) + 1;
   localparam int unsigned DEPTH   = 2 ** MEM_AW;

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE} state_t;

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [LINES-1:0]   r_valid;
   logic [31:0]        r_rdata;
   logic               r_done;
   logic               r_lat_store;
   logic [MEM_AW-1:0]  r_lat_word;
   logic [31:0]        r_lat_wdata;

   logic [TAG_W-1:0]   r_tag_mem  [LINES];
   logic [31:0]        r_data_mem [LINES];
   logic [31:0]        r_mem      [DEPTH];

`ifdef DMR_STATS_EN
   logic [31:0]        r_hit_cnt;
   logic [31:0]        r_miss_cnt;
   logic [31:0]        r_store_cnt;
`endif

   logic [MEM_AW-1:0]  w_word;
   logic [IDX_W-1:0]   w_idx;
   logic [TAG_W-1:0]   w_tag;
   logic [IDX_W-1:0]   w_lat_idx;
   logic [TAG_W-1:0]   w_lat_tag;
   logic               w_load;
   logic               w_store;
   logic               w_hit;
   logic               w_repeat;
   logic               w_idle;
   logic               w_start_fill;
   logic               w_start_write;
   logic               w_fill_done;
   logic               w_write_done;
   logic               w_unused_addr;

   assign w_word        = bus.Addr[MEM_AW+1:2];
   assign w_idx         = w_word[IDX_W-1:0];
   assign w_tag         = w_word[MEM_AW-1:IDX_W];
   assign w_lat_idx     = r_lat_word[IDX_W-1:0];
   assign w_lat_tag     = r_lat_word[MEM_AW-1:IDX_W];
   assign w_unused_addr = ^{bus.Addr[31:MEM_AW+2], bus.Addr[1:0]};

   // 2'b11 decodes as neither load nor store, i.e. no request
   assign w_load  = (bus.MEM == 2'b01);
   assign w_store = (bus.MEM == 2'b10);
   assign w_hit   = r_valid[w_idx] && (r_tag_mem[w_idx] == w_tag);

   // Requester still presenting the request that the last FILL/WRITE just completed
   assign w_repeat = r_done && (w_word == r_lat_word) &&
                     (w_store ? r_lat_store : (w_load && !r_lat_store && w_hit));

   assign w_idle        = (r_state == S_IDLE);
   assign w_start_fill  = w_idle && w_load && !w_hit;
   assign w_start_write = w_idle && w_store && !w_repeat;
   assign w_fill_done   = (r_state == S_FILL)  && (r_cnt == '0);
   assign w_write_done  = (r_state == S_WRITE) && (r_cnt == '0);

   assign bus.BUSY  = rst && (!w_idle || w_start_fill || w_start_write);
   assign bus.Rdata = r_rdata;

`ifdef DMR_STATS_EN
   assign hit_cnt   = r_hit_cnt;
   assign miss_cnt  = r_miss_cnt;
   assign store_cnt = r_store_cnt;
`endif

   // Control FSM, valid bits, read data and request latches
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_valid     <= '0;
         r_rdata     <= '0;
         r_done      <= 1'b0;
         r_lat_store <= 1'b0;
         r_lat_word  <= '0;
         r_lat_wdata <= '0;
`ifdef DMR_STATS_EN
         r_hit_cnt   <= '0;
         r_miss_cnt  <= '0;
         r_store_cnt <= '0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (!w_repeat) r_done <= 1'b0;
               if (w_load && w_hit) begin
                  r_rdata <= r_data_mem[w_idx];
`ifdef DMR_STATS_EN
                  if (!w_repeat) r_hit_cnt <= r_hit_cnt + 32'd1;
`endif
               end else if (w_load) begin
                  r_state    <= S_FILL;
                  r_lat_word <= w_word;
                  r_cnt      <= CNT_W'(MISS_LAT - 1);
`ifdef DMR_STATS_EN
                  r_miss_cnt <= r_miss_cnt + 32'd1;
`endif
               end else if (w_store && !w_repeat) begin
                  r_state     <= S_WRITE;
                  r_lat_word  <= w_word;
                  r_lat_wdata <= bus.Wdata;
                  r_cnt       <= CNT_W'(WR_LAT - 1);
`ifdef DMR_STATS_EN
                  r_store_cnt <= r_store_cnt + 32'd1;
`endif
               end
            end
            S_FILL: begin
               if (r_cnt == '0) begin
                  r_valid[w_lat_idx] <= 1'b1;
                  r_rdata            <= r_mem[r_lat_word];
                  r_state            <= S_IDLE;
                  r_done             <= 1'b1;
                  r_lat_store        <= 1'b0;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            S_WRITE: begin
               if (r_cnt == '0) begin
                  r_state     <= S_IDLE;
                  r_done      <= 1'b1;
                  r_lat_store <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Storage arrays: no reset; writes are qualified by the FSM state, which reset forces to IDLE
   always_ff @(posedge clk) begin
      if (w_fill_done) begin
         r_data_mem[w_lat_idx] <= r_mem[r_lat_word];
         r_tag_mem[w_lat_idx]  <= w_lat_tag;
      end else if (w_start_write && w_hit) begin
         r_data_mem[w_idx] <= bus.Wdata;
      end
      if (w_write_done) r_mem[r_lat_word] <= r_lat_wdata;
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder; counter checks compile in with DMR_STATS_EN.
module tb_data_mem_responder;
   logic        clk = 1'b0;
   logic        rst;
   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   data_mem_responder_if bus_if ();

`ifdef DMR_STATS_EN
   logic [31:0] hit_cnt;
   logic [31:0] miss_cnt;
   logic [31:0] store_cnt;
`endif

   data_mem_responder dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus_if)
`ifdef DMR_STATS_EN
      ,
      .hit_cnt   (hit_cnt),
      .miss_cnt  (miss_cnt),
      .store_cnt (store_cnt)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [1:0] m, input logic [31:0] a, input logic [31:0] d);
      bus_if.MEM   = m;
      bus_if.Addr  = a;
      bus_if.Wdata = d;
      #1;
   endtask

   // Counts BUSY cycles from the current one; leaves the bench in the first BUSY=0 cycle
   task automatic busy_len(input string tag, input int unsigned exp);
      int unsigned n = 0;
      while (bus_if.BUSY === 1'b1 && n < 50) begin
         n++;
         @(negedge clk);
         #1;
      end
      chk(tag, 32'(n), 32'(exp));
   endtask

   // One request held until completion, then one idle cycle in which Rdata is checked
   task automatic access(input string tag, input logic [1:0] m, input logic [31:0] a,
                         input logic [31:0] d, input int unsigned exp_busy,
                         input logic [31:0] exp_rdata);
      @(negedge clk);
      drive(m, a, d);
      busy_len({tag, "_busy_len"}, exp_busy);
      chk({tag, "_busy_done"}, 32'(bus_if.BUSY), 32'd0);
      @(negedge clk);
      drive(2'b00, 32'h0, 32'h0);
      chk({tag, "_rdata"}, bus_if.Rdata, exp_rdata);
   endtask

`ifdef DMR_STATS_EN
   task automatic chk_stats(input string tag, input logic [31:0] h, input logic [31:0] m,
                            input logic [31:0] s);
      chk({tag, "_hit_cnt"},   hit_cnt,   h);
      chk({tag, "_miss_cnt"},  miss_cnt,  m);
      chk({tag, "_store_cnt"}, store_cnt, s);
   endtask
`endif

   initial begin
      // Reset with a load presented: BUSY must stay low
      rst = 1'b0;
      drive(2'b01, 32'h40, 32'h0);
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("reset_busy",  32'(bus_if.BUSY), 32'd0);
      chk("reset_rdata", bus_if.Rdata,     32'h0);
`ifdef DMR_STATS_EN
      chk_stats("reset", 32'd0, 32'd0, 32'd0);
`endif
      @(negedge clk);
      rst = 1'b1;
      drive(2'b00, 32'h0, 32'h0);

      // Preload backing word 0x10 through an uncached store, then miss and re-hit
      access("st40_cafe", 2'b10, 32'h40, 32'hCAFEF00D, 3, 32'h0);
      access("ld40_miss", 2'b01, 32'h40, 32'h0,        5, 32'hCAFEF00D);
      access("ld40_hit",  2'b01, 32'h40, 32'h0,        0, 32'hCAFEF00D);

      // Store hit updates the cached line
      access("st40_beef", 2'b10, 32'h40, 32'hDEADBEEF, 3, 32'hCAFEF00D);
      access("ld40_hit2", 2'b01, 32'h40, 32'h0,        0, 32'hDEADBEEF);

      // Conflict eviction on index 0
      access("st00",      2'b10, 32'h00, 32'h11112222, 3, 32'hDEADBEEF);
      access("ld00_miss", 2'b01, 32'h00, 32'h0,        5, 32'h11112222);
      access("ld40_evct", 2'b01, 32'h40, 32'h0,        5, 32'hDEADBEEF);
      access("ld00_evct", 2'b01, 32'h00, 32'h0,        5, 32'h11112222);

      // No write-allocate: store to 0x80 leaves 0x00 cached
      access("st80",      2'b10, 32'h80, 32'h0BADC0DE, 3, 32'h11112222);
      access("ld00_keep", 2'b01, 32'h00, 32'h0,        0, 32'h11112222);
      access("ld80_miss", 2'b01, 32'h80, 32'h0,        5, 32'h0BADC0DE);

      // Upper and byte-offset address bits alias onto word 0x20
      access("ld_alias",  2'b01, 32'h10000083, 32'h0,  0, 32'h0BADC0DE);

      // MEM=11 is no request: no BUSY, Rdata holds
      access("mem11",     2'b11, 32'h40, 32'h0,        0, 32'h0BADC0DE);

      // Fill index 1, then back-to-back hits across two lines
      access("st44",      2'b10, 32'h44, 32'h55AA55AA, 3, 32'h0BADC0DE);
      access("ld44_miss", 2'b01, 32'h44, 32'h0,        5, 32'h55AA55AA);
      @(negedge clk);
      drive(2'b01, 32'h80, 32'h0);
      chk("b2b_busy0",  32'(bus_if.BUSY), 32'd0);
      @(negedge clk);
      drive(2'b01, 32'h44, 32'h0);
      chk("b2b_busy1",  32'(bus_if.BUSY), 32'd0);
      chk("b2b_rdata0", bus_if.Rdata,     32'h0BADC0DE);
      @(negedge clk);
      drive(2'b01, 32'h80, 32'h0);
      chk("b2b_busy2",  32'(bus_if.BUSY), 32'd0);
      chk("b2b_rdata1", bus_if.Rdata,     32'h55AA55AA);
      @(negedge clk);
      drive(2'b00, 32'h0, 32'h0);
      chk("b2b_rdata2", bus_if.Rdata,     32'h0BADC0DE);
`ifdef DMR_STATS_EN
      chk_stats("pre_rst", 32'd7, 32'd6, 32'd5);
`endif

      // Reset in the second FILL cycle aborts the miss
      @(negedge clk);
      drive(2'b01, 32'h00, 32'h0);
      chk("rf_busy_req", 32'(bus_if.BUSY), 32'd1);
      @(negedge clk);
      #1;
`ifdef DMR_STATS_EN
      chk("rf_miss_cnt", miss_cnt, 32'd7);
`endif
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rf_busy_rst",  32'(bus_if.BUSY), 32'd0);
      chk("rf_rdata_rst", bus_if.Rdata,     32'h0);
`ifdef DMR_STATS_EN
      chk_stats("rf_rst", 32'd0, 32'd0, 32'd0);
`endif
      @(negedge clk);
      rst = 1'b1;
      #1;
      busy_len("retry_busy_len", 5);
      chk("retry_busy_done", 32'(bus_if.BUSY), 32'd0);
      @(negedge clk);
      drive(2'b00, 32'h0, 32'h0);
      chk("retry_rdata", bus_if.Rdata, 32'h11112222);

      // Valid bits were cleared: index 1 misses again
      access("ld44_post", 2'b01, 32'h44, 32'h0, 5, 32'h55AA55AA);
      access("ld44_hit",  2'b01, 32'h44, 32'h0, 0, 32'h55AA55AA);
`ifdef DMR_STATS_EN
      chk_stats("final", 32'd1, 32'd2, 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
